fm_feeder: RTL and testbench

FM_FEEDER -- requirements
Module: fm_feeder

---
 rtl/fm_feeder.sv | 141 ++++++++++++++
 tb/tb_fm_feeder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_feeder.sv
// Feature-map feeder: loads a KxK weight bank, then streams one FM_SIZE x FM_SIZE
// frame from memory to the PE array followed by FLUSH_LEN zero cycles.
module fm_feeder #(
  parameter int KERNEL_SIZE = 2,
  parameter int FM_SIZE     = 4,
  parameter int FLUSH_LEN   = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rstn,
  input  logic                                  i_start,
  input  logic                                  i_abort,
  input  logic                                  i_wvalid,
  input  logic signed [17:0]                    i_wdata,
  output logic                                  o_rd_en,
  output logic [15:0]                           o_addr,
  input  logic signed [29:0]                    i_rdata,
  output logic signed [29:0]                    o_DataFM,
  output logic                                  o_en,
  output logic [KERNEL_SIZE*KERNEL_SIZE*18-1:0] o_Weight,
  output logic                                  o_wfull,
  output logic                                  o_busy,
  output logic                                  o_done
);

  localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NPIX = FM_SIZE * FM_SIZE;
  localparam int CW   = $clog2(NPIX + FLUSH_LEN + 1);
  localparam int WCW  = (KK > 1) ? $clog2(KK) : 1;
  localparam int FL_M1 = (FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0;

  typedef enum logic [2:0] {IDLE, FETCH, STREAM, FLUSH, DONE} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_addr;
  logic [CW-1:0]          r_fcnt;
  logic [WCW-1:0]         r_wcnt;
  logic                   r_vld;
  logic                   r_rd_en;
  logic                   r_en;
  logic                   r_wfull;
  logic                   r_done;
  logic signed [29:0]     r_data;
  logic [KK*18-1:0]       r_weight;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_fcnt   <= '0;
      r_wcnt   <= '0;
      r_vld    <= 1'b0;
      r_rd_en  <= 1'b0;
      r_en     <= 1'b0;
      r_wfull  <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_weight <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start && r_wfull) begin
            r_state <= FETCH;
            r_rd_en <= 1'b1;
            r_addr  <= '0;
          end else if (i_wvalid) begin
            r_weight[int'(r_wcnt)*18 +: 18] <= i_wdata;
            if (r_wcnt == WCW'(KK - 1)) begin
              r_wcnt  <= '0;
              r_wfull <= 1'b1;
            end else begin
              r_wcnt  <= r_wcnt + 1'b1;
              r_wfull <= 1'b0;
            end
          end
        end
        default: begin
          if (i_abort) begin
            r_state <= IDLE;
            r_en    <= 1'b0;
            r_rd_en <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            case (r_state)
              FETCH, STREAM: begin
                // r_vld marks that i_rdata carries the word addressed last cycle
                r_vld <= r_rd_en;
                if (r_rd_en) begin
                  if (r_addr == CW'(NPIX - 1)) r_rd_en <= 1'b0;
                  else                         r_addr  <= r_addr + 1'b1;
                end
                if (r_vld) begin
                  r_data  <= i_rdata;
                  r_en    <= 1'b1;
                  r_state <= STREAM;
                end else if (r_state == STREAM) begin
                  r_data <= '0;
                  if (FLUSH_LEN == 0) begin
                    r_en    <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                  end else begin
                    r_fcnt  <= CW'(FL_M1);
                    r_state <= FLUSH;
                  end
                end
              end
              FLUSH: begin
                if (r_fcnt == '0) begin
                  r_en    <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
                end else begin
                  r_fcnt <= r_fcnt - 1'b1;
                end
              end
              DONE: begin
                r_done  <= 1'b0;
                r_state <= IDLE;
              end
              default: r_state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign o_rd_en  = r_rd_en;
  assign o_addr   = 16'(r_addr);
  assign o_DataFM = r_data;
  assign o_en     = r_en;
  assign o_Weight = r_weight;
  assign o_wfull  = r_wfull;
  assign o_busy   = (r_state != IDLE);
  assign o_done   = r_done;

endmodule

// File: tb/tb_fm_feeder.sv
// Randomized self-checking bench for fm_feeder; expected frames come from a
// memory model plus a queue of expected pixels built from the frame rules.
module tb_fm_feeder;
  localparam int K    = 2;
  localparam int FM   = 4;
  localparam int FL   = 4;
  localparam int KK   = K * K;
  localparam int NPIX = FM * FM;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              i_start = 1'b0;
  logic              i_abort = 1'b0;
  logic              i_wvalid = 1'b0;
  logic signed [17:0] i_wdata = '0;
  logic              o_rd_en;
  logic [15:0]       o_addr;
  logic signed [29:0] i_rdata;
  logic signed [29:0] o_DataFM;
  logic              o_en;
  logic [KK*18-1:0]  o_Weight;
  logic              o_wfull, o_busy, o_done;

  int n_checks = 0;
  int n_errs   = 0;

  logic [29:0]        mem_base = 30'd100;
  logic signed [29:0] mem_rdata = '0;
  logic [17:0]        wmodel [KK];
  int                 wcnt_m = 0;
  logic               wfull_m = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) if (o_rd_en) mem_rdata <= mem_base + 30'(o_addr);
  assign i_rdata = mem_rdata;

  fm_feeder #(.KERNEL_SIZE(K), .FM_SIZE(FM), .FLUSH_LEN(FL)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(i_start), .i_abort(i_abort),
    .i_wvalid(i_wvalid), .i_wdata(i_wdata), .o_rd_en(o_rd_en), .o_addr(o_addr),
    .i_rdata(i_rdata), .o_DataFM(o_DataFM), .o_en(o_en), .o_Weight(o_Weight),
    .o_wfull(o_wfull), .o_busy(o_busy), .o_done(o_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [KK*18-1:0] exp_weights();
    logic [KK*18-1:0] v;
    for (int i = 0; i < KK; i++) v[i*18 +: 18] = wmodel[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < KK; i++) wmodel[i] = '0;
    wcnt_m  = 0;
    wfull_m = 1'b0;
  endtask

  task automatic load_weights(input int cnt, input bit rnd);
    for (int i = 0; i < cnt; i++) begin
      i_wvalid = 1'b1;
      i_wdata  = rnd ? 18'($urandom) : 18'(i + 1);
      wmodel[wcnt_m] = i_wdata;
      wcnt_m++;
      if (wcnt_m == KK) begin wcnt_m = 0; wfull_m = 1'b1; end
      else wfull_m = 1'b0;
      tick();
    end
    i_wvalid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_clear();
    tick();
    i_wvalid = 1'b1; i_wdata = 18'h155; i_start = 1'b1;
    tick();
    i_wvalid = 1'b0; i_start = 1'b0;
    n_checks++;
    if ({o_en, o_rd_en, o_wfull, o_busy, o_done} !== 5'b0) begin
      n_errs++;
      $display("FAIL reset_flags got=%b expected=00000", {o_en, o_rd_en, o_wfull, o_busy, o_done});
    end
    n_checks++;
    if (o_DataFM !== '0 || o_addr !== '0 || o_Weight !== '0) begin
      n_errs++;
      $display("FAIL reset_data data=%0d addr=%0d weight=%h expected zeros", o_DataFM, o_addr, o_Weight);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_start_without_weights();
    int hits = 0;
    load_weights(3, 1'b1);
    n_checks++;
    if (o_wfull !== 1'b0) begin
      n_errs++; $display("FAIL partial_wfull got=%b expected=0", o_wfull);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (o_rd_en || o_busy) hits++;
      tick();
    end
    n_checks++;
    if (hits != 0) begin
      n_errs++; $display("FAIL start_no_weights busy_cycles=%0d expected=0", hits);
    end
    load_weights(1, 1'b1);
    n_checks++;
    if (o_wfull !== wfull_m || o_Weight !== exp_weights()) begin
      n_errs++;
      $display("FAIL fourth_weight wfull=%b weight=%h expected wfull=%b weight=%h",
               o_wfull, o_Weight, wfull_m, exp_weights());
    end
  endtask

  task automatic test_weight_load();
    logic [KK*18-1:0] fixed_w;
    fixed_w = {18'd4, 18'd3, 18'd2, 18'd1};
    load_weights(4, 1'b0);
    n_checks++;
    if (o_wfull !== 1'b1 || o_Weight !== fixed_w) begin
      n_errs++;
      $display("FAIL weight_1234 wfull=%b weight=%h expected wfull=1 weight=%h", o_wfull, o_Weight, fixed_w);
    end
    load_weights(1, 1'b1);
    n_checks++;
    if (o_wfull !== 1'b0 || o_Weight !== exp_weights()) begin
      n_errs++;
      $display("FAIL reload_begin wfull=%b weight=%h expected wfull=0 weight=%h", o_wfull, o_Weight, exp_weights());
    end
    load_weights(3, 1'b1);
    n_checks++;
    if (o_wfull !== 1'b1 || o_Weight !== exp_weights()) begin
      n_errs++;
      $display("FAIL reload_end wfull=%b weight=%h expected wfull=1 weight=%h", o_wfull, o_Weight, exp_weights());
    end
  endtask

  task automatic run_frame(input logic [29:0] base, input bit hold, input string tag);
    logic signed [29:0] exp_q[$];
    logic signed [29:0] got_q[$];
    int first_en = -1, done_cnt = 0, rd_cnt = 0, addr_err = 0, gaps = 0, data_err = 0, extra = 0;
    bit en_prev = 1'b0, ended = 1'b0;
    mem_base = base;
    for (int k = 0; k < NPIX; k++) exp_q.push_back(30'(base + 30'(k)));
    for (int k = 0; k < FL; k++) exp_q.push_back('0);
    i_start = 1'b1;
    tick();
    if (!hold) i_start = 1'b0;
    n_checks++;
    if (o_rd_en !== 1'b1 || o_addr !== 16'd0 || o_busy !== 1'b1) begin
      n_errs++;
      $display("FAIL %s_fetch rd_en=%b addr=%0d busy=%b expected 1/0/1", tag, o_rd_en, o_addr, o_busy);
    end
    rd_cnt = 1;
    for (int c = 1; c <= 80 && !ended; c++) begin
      tick();
      if (o_rd_en) begin
        if (o_addr != 16'(rd_cnt)) addr_err++;
        rd_cnt++;
      end
      if (o_en) begin
        if (first_en < 0) first_en = c;
        else if (!en_prev) gaps++;
        got_q.push_back(o_DataFM);
      end
      if (o_done) begin
        done_cnt++;
        i_start = 1'b0;
      end
      en_prev = o_en;
      if (done_cnt > 0 && !o_done) ended = 1'b1;
    end
    i_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (o_done || o_rd_en || o_busy || o_en) extra++;
      tick();
    end
    n_checks++;
    if (!ended) begin
      n_errs++; $display("FAIL %s_timeout done_cnt=%0d expected frame end within 80 cycles", tag, done_cnt);
    end
    n_checks++;
    if (first_en != 2) begin
      n_errs++; $display("FAIL %s_latency first_en_cycle=%0d expected=2", tag, first_en);
    end
    n_checks++;
    if (got_q.size() != exp_q.size() || gaps != 0) begin
      n_errs++;
      $display("FAIL %s_en_len en_cycles=%0d gaps=%0d expected %0d/0", tag, got_q.size(), gaps, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      if (got_q[k] !== exp_q[k]) data_err++;
    n_checks++;
    if (data_err != 0) begin
      n_errs++;
      $display("FAIL %s_data wrong_pixels=%0d first got=%0d expected=%0d", tag, data_err,
               got_q.size() > 0 ? got_q[0] : 30'sd0, exp_q[0]);
    end
    n_checks++;
    if (rd_cnt != NPIX || addr_err != 0) begin
      n_errs++;
      $display("FAIL %s_reads reads=%0d addr_errs=%0d expected %0d/0", tag, rd_cnt, addr_err, NPIX);
    end
    n_checks++;
    if (done_cnt != 1 || extra != 0) begin
      n_errs++;
      $display("FAIL %s_done done_pulses=%0d after_activity=%0d expected 1/0", tag, done_cnt, extra);
    end
  endtask

  task automatic test_abort();
    int en_seen = 0, done_seen = 0, c = 0;
    mem_base = 30'($urandom_range(0, 1 << 20));
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (en_seen < 6 && c < 40) begin
      tick();
      c++;
      if (o_en) en_seen++;
    end
    n_checks++;
    if (en_seen != 6) begin
      n_errs++; $display("FAIL abort_reach en_cycles=%0d expected=6", en_seen);
    end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_checks++;
    if ({o_en, o_rd_en, o_busy, o_done} !== 4'b0 || o_addr !== '0 || o_DataFM !== '0) begin
      n_errs++;
      $display("FAIL abort_clear en=%b rd=%b busy=%b done=%b addr=%0d data=%0d expected zeros",
               o_en, o_rd_en, o_busy, o_done, o_addr, o_DataFM);
    end
    for (int i = 0; i < 10; i++) begin
      if (o_done || o_en) done_seen++;
      tick();
    end
    n_checks++;
    if (done_seen != 0 || o_wfull !== 1'b1 || o_Weight !== exp_weights()) begin
      n_errs++;
      $display("FAIL abort_after activity=%0d wfull=%b weight=%h expected 0/1/%h",
               done_seen, o_wfull, o_Weight, exp_weights());
    end
    run_frame(30'($urandom_range(0, 1 << 20)), 1'b0, "restart");
  endtask

  task automatic test_start_abort_idle();
    i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_rd_en !== 1'b1) begin
      n_errs++; $display("FAIL start_abort_idle busy=%b rd_en=%b expected 1/1", o_busy, o_rd_en);
    end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || o_rd_en !== 1'b0) begin
      n_errs++; $display("FAIL abort_fetch busy=%b rd_en=%b expected 0/0", o_busy, o_rd_en);
    end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    int en_seen = 0, hits = 0, c = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (en_seen < 3 && c < 40) begin
      tick();
      c++;
      if (o_en) en_seen++;
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({o_en, o_rd_en, o_wfull, o_busy, o_done} !== 5'b0 || o_DataFM !== '0 || o_addr !== '0 || o_Weight !== '0) begin
      n_errs++;
      $display("FAIL reset_mid en=%b rd=%b wfull=%b busy=%b done=%b data=%0d addr=%0d weight=%h expected zeros",
               o_en, o_rd_en, o_wfull, o_busy, o_done, o_DataFM, o_addr, o_Weight);
    end
    model_clear();
    tick();
    rstn = 1'b1;
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (o_busy || o_rd_en || o_en) hits++;
      tick();
    end
    n_checks++;
    if (hits != 0) begin
      n_errs++; $display("FAIL reset_start_ignored active_cycles=%0d expected=0", hits);
    end
    load_weights(KK, 1'b1);
    n_checks++;
    if (o_wfull !== 1'b1 || o_Weight !== exp_weights()) begin
      n_errs++;
      $display("FAIL reset_reload wfull=%b weight=%h expected 1/%h", o_wfull, o_Weight, exp_weights());
    end
    run_frame(30'($urandom_range(0, 1 << 24)), 1'b0, "post_reset");
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 3; n++) begin
      load_weights(KK, 1'b1);
      n_checks++;
      if (o_Weight !== exp_weights() || o_wfull !== 1'b1) begin
        n_errs++;
        $display("FAIL rand_weights iter=%0d weight=%h expected=%h", n, o_Weight, exp_weights());
      end
      run_frame(30'($urandom), 1'b0, "rand_frame");
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_start_without_weights();
    test_weight_load();
    run_frame(30'd100, 1'b0, "frame100");
    test_abort();
    test_start_abort_idle();
    run_frame(30'($urandom_range(0, 1000)), 1'b1, "start_held");
    test_reset_mid_stream();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
